// File: rtl/rice_residual_assembler_pkg.sv
// Shared types and helpers for the Rice residual assembler.
// Holds the sequencer state encoding and the zigzag unfold.
package rice_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_PARAM,
      ST_DECODE,
      ST_DRAIN
   } state_e;

   localparam int DATA_W_DEFAULT = 16;

   // Unfold is computed at a fixed wide width; callers truncate to their
   // own width, which yields the same low bits as a native-width unfold.
   localparam int UNFOLD_W = 32;

   // Reserved Rice parameter; escape partitions are resolved upstream.
   localparam logic [3:0] RICE_ESCAPE = 4'hF;

   function automatic logic [UNFOLD_W-1:0] unfold(input logic [UNFOLD_W-1:0] u);
      return (u >> 1) ^ {UNFOLD_W{u[0]}};
   endfunction

endpackage

// File: rtl/rice_residual_assembler_fifo.sv
// Synchronous first-word-fall-through queue for decoded residuals.
// A push into a full queue is accepted only when a pop happens on the same edge.
module residual_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic              do_push, do_pop;

   always_comb begin
      empty   = (cnt_q == '0);
      full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
      head = empty ? '0 : mem_q[rd_q];
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rice_residual_assembler.sv
// Rebuilds Rice-coded residuals from (quotient, remainder) pairs, tracks
// partition boundaries, requests Rice parameters and flags block completion.
module rice_residual_assembler
   import rice_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              iClock,
   input  logic              iReset,
   input  logic              iStart,
   input  logic [15:0]       iBlockSize,
   input  logic [3:0]        iPartOrder,
   input  logic [5:0]        iPredOrder,
   input  logic [3:0]        iRiceParam,
   input  logic              iParamValid,
   input  logic [DATA_W-1:0] iMSB,
   input  logic [DATA_W-1:0] iLSB,
   input  logic              iDone,
   output logic              oNeedParam,
   output logic [DATA_W-1:0] oResidual,
   output logic              oValid,
   input  logic              iReady,
   output logic              oPartDone,
   output logic              oBlockDone,
   output logic              oOverflow
);

   state_e            state_q, state_d;
   logic [15:0]       bs_q, bs_d, rem_q, rem_d;
   logic [3:0]        p_q, p_d, k_q, k_d;
   logic [16:0]       part_q, part_d, num_parts;
   logic              need_q, need_d;
   logic              part_done_q, part_done_d;
   logic              block_done_q, block_done_d;
   logic              ovf_q, ovf_d;
   logic              push, pop, full, empty, param_accept, boundary;
   logic [DATA_W-1:0] u, residual, head;

   residual_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (iClock),
      .rst   (iReset),
      .push  (push),
      .din   (residual),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      u            = (iMSB << k_q) | iLSB;
      residual     = DATA_W'(unfold(UNFOLD_W'(u)));
      num_parts    = 17'd1 << p_q;
      pop          = !empty && iReady;
      param_accept = (state_q == ST_WAIT_PARAM) && need_q && iParamValid;
      state_d      = state_q;
      bs_d         = bs_q;
      p_d          = p_q;
      k_d          = k_q;
      rem_d        = rem_q;
      part_d       = part_q;
      ovf_d        = ovf_q;
      part_done_d  = 1'b0;
      block_done_d = 1'b0;
      push         = 1'b0;
      boundary     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               bs_d    = iBlockSize;
               p_d     = iPartOrder;
               part_d  = '0;
               rem_d   = (iBlockSize >> iPartOrder) - 16'(iPredOrder);
               ovf_d   = 1'b0;
               state_d = ST_WAIT_PARAM;
            end
         end
         ST_WAIT_PARAM: begin
            if (param_accept) begin
               k_d = iRiceParam;
               if (rem_q == '0) begin
                  boundary = 1'b1;
               end else begin
                  state_d = ST_DECODE;
               end
            end
         end
         ST_DECODE: begin
            if (iDone) begin
               push = 1'b1;
               if (full && !pop) begin
                  ovf_d = 1'b1;
               end
               rem_d = rem_q - 16'd1;
               if (rem_d == '0) begin
                  boundary = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (empty) begin
               block_done_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (boundary) begin
         part_done_d = 1'b1;
         part_d      = part_q + 17'd1;
         if (part_d == num_parts) begin
            state_d = ST_DRAIN;
         end else begin
            rem_d   = bs_q >> p_q;
            state_d = ST_WAIT_PARAM;
         end
      end

      // Request drops for one cycle after an accept so a held iParamValid
      // is not taken again for the following (empty-partition) request.
      need_d = (state_d == ST_WAIT_PARAM) && !param_accept;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q      <= ST_IDLE;
         bs_q         <= '0;
         p_q          <= '0;
         k_q          <= '0;
         rem_q        <= '0;
         part_q       <= '0;
         need_q       <= 1'b0;
         part_done_q  <= 1'b0;
         block_done_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bs_q         <= bs_d;
         p_q          <= p_d;
         k_q          <= k_d;
         rem_q        <= rem_d;
         part_q       <= part_d;
         need_q       <= need_d;
         part_done_q  <= part_done_d;
         block_done_q <= block_done_d;
         ovf_q        <= ovf_d;
      end
   end

   assign oNeedParam = need_q;
   assign oResidual  = head;
   assign oValid     = !empty;
   assign oPartDone  = part_done_q;
   assign oBlockDone = block_done_q;
   assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_rice_residual_assembler.sv
// Directed and randomized bench for rice_residual_assembler against an
// arithmetic reference model of the residual stream and queue occupancy.
module tb_rice_residual_assembler;

   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          iReset = 1'b1, iStart = 1'b0, iParamValid = 1'b0, iDone = 1'b0, iReady = 1'b0;
   logic [15:0]   iBlockSize = '0;
   logic [3:0]    iPartOrder = '0, iRiceParam = '0;
   logic [5:0]    iPredOrder = '0;
   logic [DW-1:0] iMSB = '0, iLSB = '0;
   logic          oNeedParam, oValid, oPartDone, oBlockDone, oOverflow;
   logic [DW-1:0] oResidual;

   int            checks = 0, errors = 0;
   int            pd_cnt = 0, bd_cnt = 0;
   logic [15:0]   exp_q[$];
   bit            model_ovf = 1'b0;
   int unsigned   cur_k = 0;

   always #5 clk = ~clk;

   rice_residual_assembler #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .iClock      (clk),
      .iReset      (iReset),
      .iStart      (iStart),
      .iBlockSize  (iBlockSize),
      .iPartOrder  (iPartOrder),
      .iPredOrder  (iPredOrder),
      .iRiceParam  (iRiceParam),
      .iParamValid (iParamValid),
      .iMSB        (iMSB),
      .iLSB        (iLSB),
      .iDone       (iDone),
      .oNeedParam  (oNeedParam),
      .oResidual   (oResidual),
      .oValid      (oValid),
      .iReady      (iReady),
      .oPartDone   (oPartDone),
      .oBlockDone  (oBlockDone),
      .oOverflow   (oOverflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Folded value rebuilt as msb*2^k+lsb modulo 2^16, then mapped back to
   // a signed integer: even u -> u/2, odd u -> -(u+1)/2.
   function automatic logic [15:0] model_res(int unsigned msb, int unsigned lsb, int unsigned k);
      longint unsigned uu;
      longint          r;
      uu = ((longint'(msb) << k) + longint'(lsb)) % 65536;
      if (uu % 2 == 0) r = longint'(uu / 2);
      else             r = -longint'((uu + 1) / 2);
      return r[15:0];
   endfunction

   // Consumer side: checks occupancy and each popped head against the model.
   always @(negedge clk) begin
      if (!iReset) begin
         chk("valid", 32'(oValid), 32'(exp_q.size() != 0));
         if (oValid && iReady && exp_q.size() > 0) begin
            chk("residual", 32'(oResidual), 32'(exp_q[0]));
            void'(exp_q.pop_front());
         end
      end
      if (oPartDone)  pd_cnt++;
      if (oBlockDone) bd_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input int unsigned bs, input int unsigned p, input int unsigned pred);
      iBlockSize = 16'(bs);
      iPartOrder = 4'(p);
      iPredOrder = 6'(pred);
      iStart     = 1'b1;
      pd_cnt     = 0;
      bd_cnt     = 0;
      model_ovf  = 1'b0;
      tick();
      iStart = 1'b0;
   endtask

   task automatic wait_need();
      for (int unsigned i = 0; i < 20 && !oNeedParam; i++) tick();
      chk("need_param", 32'(oNeedParam), 32'd1);
   endtask

   task automatic give_param(input int unsigned k);
      wait_need();
      iRiceParam  = 4'(k);
      iParamValid = 1'b1;
      cur_k       = k;
      tick();
      iParamValid = 1'b0;
   endtask

   task automatic send_core(input int unsigned msb, input int unsigned lsb, input logic [15:0] expv);
      bit drop;
      iMSB  = DW'(msb);
      iLSB  = DW'(lsb);
      iDone = 1'b1;
      drop  = (exp_q.size() == DEPTH) && !iReady;
      if (drop) model_ovf = 1'b1;
      tick();
      iDone = 1'b0;
      if (!drop) exp_q.push_back(expv);
      chk("overflow", 32'(oOverflow), 32'(model_ovf));
   endtask

   task automatic send_rand(input bit rand_ready);
      int unsigned msb, lsb;
      msb = $urandom_range(0, 40);
      lsb = (cur_k == 0) ? 0 : $urandom_range(0, (1 << cur_k) - 1);
      if (rand_ready) iReady = 1'($urandom_range(0, 1));
      send_core(msb, lsb, model_res(msb, lsb, cur_k));
   endtask

   task automatic wait_done(input int unsigned nparts);
      iReady = 1'b1;
      for (int unsigned i = 0; i < 40 && bd_cnt == 0; i++) tick();
      chk("block_done", 32'(bd_cnt), 32'd1);
      chk("block_done_pulse", 32'(oBlockDone), 32'd0);
      chk("part_count", 32'(pd_cnt), 32'(nparts));
      chk("drained", 32'(exp_q.size()), 32'd0);
      chk("idle_need", 32'(oNeedParam), 32'd0);
   endtask

   task automatic run_block(input int unsigned size, input int unsigned p, input int unsigned pred);
      int unsigned n;
      start_block(size << p, p, pred);
      for (int unsigned part = 0; part < (1 << p); part++) begin
         n = (part == 0) ? size - pred : size;
         give_param($urandom_range(0, 15));
         for (int unsigned w = 0; w < n; w++) send_rand(1'b1);
      end
      wait_done(1 << p);
   endtask

   int t1m[5] = '{5, 2, 0, 5, 11};
   int t1l[5] = '{5, 6, 2, 7, 1};
   int t1e[5] = '{-23, 11, 1, -24, -45};

   initial begin
      int unsigned sz, pp, pr;

      tick();
      tick();
      iReset = 1'b0;
      chk("reset_flags", {27'd0, oValid, oNeedParam, oOverflow, oPartDone, oBlockDone}, 32'd0);
      chk("reset_residual", 32'(oResidual), 32'd0);

      // Five code words in one partition, k=3
      start_block(5, 0, 0);
      give_param(3);
      chk("t1_need_low", 32'(oNeedParam), 32'd0);
      iReady = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         send_core(t1m[i], t1l[i], 16'(t1e[i]));
         chk("t1_part_done", 32'(oPartDone), 32'(i == 4));
      end
      wait_done(1);

      // Two partitions, first shortened by the predictor order
      start_block(8, 1, 2);
      give_param(3);
      send_rand(1'b1);
      chk("t2_need_mid", 32'(oNeedParam), 32'd0);
      send_rand(1'b1);
      chk("t2_part0_done", 32'(oPartDone), 32'd1);
      chk("t2_need_again", 32'(oNeedParam), 32'd1);
      give_param(0);
      send_core(3, 0, 16'hFFFE);
      for (int unsigned i = 0; i < 3; i++) send_rand(1'b1);
      wait_done(2);

      // Empty first partition
      start_block(8, 2, 2);
      give_param(5);
      chk("t3_part_done", 32'(oPartDone), 32'd1);
      chk("t3_need_gap", 32'(oNeedParam), 32'd0);
      tick();
      chk("t3_need_back", 32'(oNeedParam), 32'd1);
      for (int unsigned part = 1; part < 4; part++) begin
         give_param($urandom_range(0, 15));
         send_rand(1'b1);
         send_rand(1'b1);
      end
      wait_done(4);

      // Overflow with consumer stalled
      start_block(5, 0, 0);
      give_param(2);
      iReady = 1'b0;
      for (int unsigned i = 0; i < 5; i++) send_rand(1'b0);
      chk("t4_overflow_set", 32'(oOverflow), 32'd1);
      wait_done(1);

      // Full queue with a simultaneous pop on the fifth word
      start_block(5, 0, 0);
      chk("t4_overflow_clear", 32'(oOverflow), 32'd0);
      give_param(2);
      iReady = 1'b0;
      for (int unsigned i = 0; i < 4; i++) send_rand(1'b0);
      iReady = 1'b1;
      send_rand(1'b0);
      chk("t4_no_overflow", 32'(oOverflow), 32'd0);
      wait_done(1);

      // Reset mid-DECODE with two queued residuals
      start_block(8, 0, 0);
      give_param(4);
      iReady = 1'b0;
      send_rand(1'b0);
      send_rand(1'b0);
      iReset = 1'b1;
      tick();
      iReset = 1'b0;
      exp_q.delete();
      model_ovf = 1'b0;
      chk("t5_flags", {29'd0, oValid, oNeedParam, oOverflow}, 32'd0);
      chk("t5_residual", 32'(oResidual), 32'd0);
      iReady = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         iMSB  = DW'($urandom_range(0, 40));
         iDone = 1'b1;
         tick();
         chk("t5_no_push", 32'(oValid), 32'd0);
      end
      iDone = 1'b0;

      // iStart during DECODE must not disturb the running block
      start_block(4, 0, 0);
      give_param(1);
      iReady = 1'b1;
      send_rand(1'b0);
      iBlockSize = 16'd16;
      iPartOrder = 4'd3;
      iStart     = 1'b1;
      tick();
      iStart = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         send_rand(1'b0);
         chk("t6_start_ignored", 32'(oPartDone), 32'(i == 2));
      end
      wait_done(1);

      // iDone during WAIT_PARAM must not push nor count
      start_block(2, 0, 0);
      wait_need();
      iMSB  = DW'(7);
      iDone = 1'b1;
      tick();
      iDone = 1'b0;
      chk("t6_wait_no_push", 32'(oValid), 32'd0);
      give_param(2);
      send_rand(1'b0);
      chk("t6_rem_kept", 32'(oPartDone), 32'd0);
      send_rand(1'b0);
      chk("t6_part_end", 32'(oPartDone), 32'd1);
      wait_done(1);

      // Randomized blocks
      for (int unsigned b = 0; b < 8; b++) begin
         pp = $urandom_range(0, 2);
         sz = $urandom_range(1, 5);
         pr = $urandom_range(0, (sz < 3) ? sz : 3);
         run_block(sz, pp, pr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
